// File: rtl/avr_spi_pkg.sv
// ============================================================================
// Module   : avr_spi_pkg
// Purpose  : Shared types and helpers for the AVR-style SPI peripheral engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package avr_spi_pkg;

    localparam int SPI_W = 8;

    // Bit layout mirrors the AVR SPCR register, MSB first.
    typedef struct packed {
        logic       spie;
        logic       spe;
        logic       dord;
        logic       mstr;
        logic       cpol;
        logic       cpha;
        logic [1:0] spr;
    } spcr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    function automatic spcr_t dbus2spcr(input logic [7:0] dbus);
        return spcr_t'(dbus);
    endfunction

    function automatic spi_mode_t spi_mode(input spcr_t c);
        return spi_mode_t'({c.cpol, c.cpha});
    endfunction

    // First bit to leave the shifter for the selected bit order.
    function automatic logic first_bit(input logic [SPI_W-1:0] d, input logic dord);
        return dord ? d[0] : d[SPI_W-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/avr_spi_sync.sv
// ============================================================================
// Module   : avr_spi_sync
// Purpose  : Multi-flop synchronizer with a selectable reset (idle) value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avr_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{i_rst_val}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/avr_spi_slave.sv
// ============================================================================
// Module   : avr_spi_slave
// Purpose  : SPI peripheral-mode shift engine; external SCK/MOSI/SS_n are
//            oversampled in the clk domain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avr_spi_slave
    import avr_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  spcr_t             spcr,
    input  logic              sck_i,
    input  logic              mosi_i,
    input  logic              ss_n_i,
    output logic              miso_o,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              wcol,
    output logic              busy
);

    localparam logic [3:0] c_LAST_BIT = 4'(DATA_W - 1);

    logic w_sck_s, w_mosi_s, w_ss_s;
    logic r_sck_d, r_ss_d;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic [3:0]        r_bit_cnt;
    logic              r_sample;
    logic              r_first;
    logic              r_miso, r_miso_oe, r_rx_done, r_wcol;

    avr_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .i_rst_val(spcr.cpol), .i_d(sck_i), .o_q(w_sck_s)
    );
    avr_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_rst_val(1'b0), .i_d(mosi_i), .o_q(w_mosi_s)
    );
    avr_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .i_rst_val(1'b1), .i_d(ss_n_i), .o_q(w_ss_s)
    );

    logic      w_enable, w_lead, w_trail, w_shift_on_lead, w_shift_edge, w_sample_edge;
    logic      w_ss_fall, w_busy, w_tx_accept;
    logic      w_unused;
    spi_mode_t w_mode;
    logic [DATA_W-1:0] w_assembled, w_shifted, w_next_shift;
    logic              w_next_bit;

    assign w_enable  = spcr.spe & ~spcr.mstr;
    assign w_mode    = spi_mode(spcr);
    assign w_lead    = (w_sck_s != spcr.cpol) && (r_sck_d == spcr.cpol);
    assign w_trail   = (w_sck_s == spcr.cpol) && (r_sck_d != spcr.cpol);
    assign w_ss_fall = r_ss_d & ~w_ss_s;

    assign w_shift_on_lead = (w_mode == MODE1) || (w_mode == MODE3);
    assign w_shift_edge    = w_shift_on_lead ? w_lead  : w_trail;
    assign w_sample_edge   = w_shift_on_lead ? w_trail : w_lead;

    // The final bit is taken straight from the synchronizer so the byte is
    // complete on the sample edge itself; earlier bits travel via r_sample.
    assign w_assembled = spcr.dord ? {w_mosi_s, r_shift[DATA_W-1:1]}
                                   : {r_shift[DATA_W-2:0], w_mosi_s};
    assign w_shifted   = spcr.dord ? {r_sample, r_shift[DATA_W-1:1]}
                                   : {r_shift[DATA_W-2:0], r_sample};
    assign w_next_bit  = spcr.dord ? r_shift[1] : r_shift[DATA_W-2];

    assign w_busy       = (r_state == SHIFT) && ((r_bit_cnt != 4'd0) || r_first);
    assign w_tx_accept  = tx_wr & ~w_busy;
    assign w_next_shift = w_tx_accept ? tx_data : r_shift;
    assign w_unused     = ^{spcr.spie, spcr.spr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_d   <= spcr.cpol;
            r_ss_d    <= 1'b1;
            r_state   <= IDLE;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= 4'd0;
            r_sample  <= 1'b0;
            r_first   <= 1'b0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_rx_done <= 1'b0;
            r_wcol    <= 1'b0;
        end else begin
            r_sck_d   <= w_sck_s;
            r_ss_d    <= w_ss_s;
            r_rx_done <= 1'b0;
            r_wcol    <= 1'b0;

            if (tx_wr) begin
                if (w_busy) begin
                    r_wcol <= 1'b1;
                end else begin
                    r_shift <= tx_data;
                    if (!spcr.cpha && !w_ss_s && w_enable) begin
                        r_miso <= first_bit(tx_data, spcr.dord);
                    end
                end
            end

            if (!w_enable) begin
                r_state   <= IDLE;
                r_bit_cnt <= 4'd0;
                r_first   <= 1'b0;
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso_oe <= 1'b0;
                        if (w_ss_fall) begin
                            r_state   <= SHIFT;
                            r_bit_cnt <= 4'd0;
                            r_first   <= 1'b0;
                            r_miso_oe <= 1'b1;
                            if (!spcr.cpha) begin
                                r_miso <= first_bit(w_next_shift, spcr.dord);
                            end
                        end
                    end
                    SHIFT: begin
                        if (w_ss_s) begin
                            r_state   <= IDLE;
                            r_bit_cnt <= 4'd0;
                            r_first   <= 1'b0;
                            r_miso_oe <= 1'b0;
                        end else begin
                            // A shift edge before any sample only presents bit 0 (cpha=1);
                            // with cpha=0 it is the previous byte's trailing edge.
                            if (w_shift_edge) begin
                                if (r_bit_cnt != 4'd0) begin
                                    r_shift <= w_shifted;
                                    r_miso  <= w_next_bit;
                                end else if (spcr.cpha && !r_first) begin
                                    r_miso <= first_bit(w_next_shift, spcr.dord);
                                end
                            end
                            if (w_lead) begin
                                r_first <= 1'b1;
                            end
                            if (w_sample_edge) begin
                                if (r_bit_cnt == c_LAST_BIT) begin
                                    r_rx_data <= w_assembled;
                                    r_shift   <= w_assembled;
                                    r_rx_done <= 1'b1;
                                    r_state   <= DONE;
                                    r_bit_cnt <= 4'd0;
                                    r_first   <= 1'b0;
                                end else begin
                                    r_sample  <= w_mosi_s;
                                    r_bit_cnt <= r_bit_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        r_bit_cnt <= 4'd0;
                        r_first   <= 1'b0;
                        if (!w_ss_s) begin
                            r_state <= SHIFT;
                            if (!spcr.cpha) begin
                                r_miso <= first_bit(w_next_shift, spcr.dord);
                            end
                        end else begin
                            r_state   <= IDLE;
                            r_miso_oe <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign miso_o  = r_miso;
    assign miso_oe = r_miso_oe;
    assign rx_data = r_rx_data;
    assign rx_done = r_rx_done;
    assign wcol    = r_wcol;
    assign busy    = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_avr_spi_slave.sv
// ============================================================================
// Module   : tb_avr_spi_slave
// Purpose  : Directed plus randomized bench; an SPI master model drives the
//            slave and a transmit-register model predicts MISO bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avr_spi_slave;
    import avr_spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    spcr_t      spcr;
    logic       sck, mosi, ss_n;
    logic       miso_o, miso_oe;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic [7:0] rx_data;
    logic       rx_done, wcol, busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rx   = 0;
    int n_wcol = 0;
    int n_both = 0;
    int n_oe   = 0;
    int n_busy = 0;

    logic [7:0] m_tx;

    avr_spi_slave #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .spcr(spcr),
        .sck_i(sck), .mosi_i(mosi), .ss_n_i(ss_n),
        .miso_o(miso_o), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_wr(tx_wr),
        .rx_data(rx_data), .rx_done(rx_done), .wcol(wcol), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) n_rx++;
        if (wcol) n_wcol++;
        if (rx_done && wcol) n_both++;
        if (miso_oe) n_oe++;
        if (busy) n_busy++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic dord,
                            input logic spe, input logic mstr);
        @(negedge clk);
        spcr      = dbus2spcr(8'h00);
        spcr.spe  = spe;
        spcr.mstr = mstr;
        spcr.dord = dord;
        spcr.cpol = cpol;
        spcr.cpha = cpha;
        sck       = cpol;
        repeat (6) @(negedge clk);
    endtask

    // Writes happen only while the slave is idle, so the model always takes them.
    task automatic write_tx(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
        m_tx    = v;
    endtask

    task automatic ss_assert();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_release();
        @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic half_period(input int edges, input int wr_edge, input logic [7:0] wr_val);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (edges == wr_edge && k == 2) begin
                tx_data = wr_val;
                tx_wr   = 1'b1;
            end else begin
                tx_wr = 1'b0;
            end
        end
    endtask

    // SPI master: SCK at clk/8, MISO sampled on the master's sample edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, input int wr_edge,
                        input logic [7:0] wr_val, output logic [7:0] mi);
        int edges;
        int idx;
        edges = 0;
        mi    = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            idx = spcr.dord ? b : 7 - b;
            if (!spcr.cpha) mosi = mo[idx];
            half_period(edges, wr_edge, wr_val);
            if (!spcr.cpha) mi[idx] = miso_o;
            sck = ~spcr.cpol;
            if (spcr.cpha) mosi = mo[idx];
            edges++;
            half_period(edges, wr_edge, wr_val);
            if (spcr.cpha) mi[idx] = miso_o;
            sck = spcr.cpol;
            edges++;
        end
        half_period(edges, -1, 8'h00);
    endtask

    initial begin
        logic [7:0] mi, mi2, mo;
        int rx0, wc0, oe0, bz0;

        rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        tx_data = 8'h00; tx_wr = 1'b0; m_tx = 8'h00;
        spcr = dbus2spcr(8'b0100_0000);
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, miso_o, miso_oe, rx_done, wcol, busy, rx_data}, 32'd0);
        rst = 1'b0;

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        write_tx(8'h3C);
        rx0 = n_rx; wc0 = n_wcol;
        ss_assert();
        check("m0_oe_on_select", {31'd0, miso_oe}, 32'd1);
        check("m0_first_bit", {31'd0, miso_o}, {31'd0, m_tx[7]});
        check("m0_not_busy_before_edge", {31'd0, busy}, 32'd0);
        xfer(8'hA5, 8, -1, 8'h00, mi);
        ss_release();
        check("m0_miso_byte", {24'd0, mi}, {24'd0, m_tx});
        check("m0_rx_data", {24'd0, rx_data}, 32'h A5);
        check("m0_rx_done_count", n_rx - rx0, 1);
        check("m0_no_wcol", n_wcol - wc0, 0);
        check("m0_oe_off", {31'd0, miso_oe}, 32'd0);
        m_tx = 8'hA5;

        // Mode 3, LSB first
        set_mode(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        write_tx(8'h81);
        ss_assert();
        xfer(8'h96, 8, -1, 8'h00, mi);
        ss_release();
        check("m3_miso_byte", {24'd0, mi}, {24'd0, m_tx});
        check("m3_rx_data", {24'd0, rx_data}, 32'h96);
        m_tx = 8'h96;

        // Back-to-back bytes under one select: second byte echoes the first
        set_mode(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        write_tx(8'h5A);
        rx0 = n_rx;
        ss_assert();
        xfer(8'h11, 8, -1, 8'h00, mi);
        check("b2b_rx_first", {24'd0, rx_data}, 32'h11);
        m_tx = 8'h11;
        xfer(8'h22, 8, -1, 8'h00, mi2);
        ss_release();
        check("b2b_miso_first", {24'd0, mi}, 32'h5A);
        check("b2b_miso_echo", {24'd0, mi2}, {24'd0, m_tx});
        check("b2b_rx_last", {24'd0, rx_data}, 32'h22);
        check("b2b_rx_done_count", n_rx - rx0, 2);
        m_tx = 8'h22;

        // Write collision after three SCK edges
        write_tx(8'hC3);
        rx0 = n_rx; wc0 = n_wcol;
        ss_assert();
        xfer(8'h3E, 8, 3, 8'h55, mi);
        ss_release();
        check("wcol_count", n_wcol - wc0, 1);
        check("wcol_miso_unchanged", {24'd0, mi}, 32'hC3);
        check("wcol_rx_done", n_rx - rx0, 1);
        check("wcol_rx_data", {24'd0, rx_data}, 32'h3E);
        check("wcol_not_with_done", n_both, 0);
        m_tx = 8'h3E;

        // Abort after five bits, then a full byte
        rx0 = n_rx;
        ss_assert();
        xfer(8'hFF, 5, -1, 8'h00, mi);
        ss_release();
        check("abort_no_rx_done", n_rx - rx0, 0);
        check("abort_rx_kept", {24'd0, rx_data}, 32'h3E);
        check("abort_oe_off", {31'd0, miso_oe}, 32'd0);
        check("abort_not_busy", {31'd0, busy}, 32'd0);
        ss_assert();
        xfer(8'h0F, 8, -1, 8'h00, mi);
        ss_release();
        check("abort_next_rx", {24'd0, rx_data}, 32'h0F);
        check("abort_next_rx_done", n_rx - rx0, 1);

        // Disabled (spe=0, then mstr=1): no activity, but tx_wr still loads
        set_mode(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        write_tx(8'h77);
        rx0 = n_rx; oe0 = n_oe; bz0 = n_busy;
        ss_assert();
        xfer(8'hAA, 8, -1, 8'h00, mi);
        ss_release();
        set_mode(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        ss_assert();
        xfer(8'h33, 8, -1, 8'h00, mi);
        ss_release();
        check("dis_no_rx_done", n_rx - rx0, 0);
        check("dis_no_oe", n_oe - oe0, 0);
        check("dis_no_busy", n_busy - bz0, 0);
        set_mode(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ss_assert();
        xfer(8'h01, 8, -1, 8'h00, mi);
        ss_release();
        check("dis_tx_kept", {24'd0, mi}, 32'h77);
        m_tx = 8'h01;

        // Reset in the middle of a byte
        ss_assert();
        xfer(8'hC9, 3, -1, 8'h00, mi);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {19'd0, miso_o, miso_oe, rx_done, wcol, busy, rx_data}, 32'd0);
        rst = 1'b0;
        ss_release();
        m_tx = 8'h00;

        // Randomized transfers against the transmit-register model
        for (int t = 0; t < 20; t++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
            mo  = 8'($urandom);
            rx0 = n_rx;
            ss_assert();
            xfer(mo, 8, -1, 8'h00, mi);
            ss_release();
            check("rnd_miso", {24'd0, mi}, {24'd0, m_tx});
            check("rnd_rx_data", {24'd0, rx_data}, {24'd0, mo});
            check("rnd_rx_done", n_rx - rx0, 1);
            m_tx = mo;
        end
        check("no_wcol_with_done", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avr_spi_slave.md
Name: avr_spi_slave

Overview:
- SPI peripheral-mode (slave) shift engine: the far end of the SPCR-configured SPI master, for XLR8 when SPCR.MSTR=0.
- Samples external SCK/MOSI/SS_n in the `clk` domain, shifts bytes in and out per SPCR.DORD/CPOL/CPHA, and reports completion and collision events to the register block (SPDR/SPSR owner).
- Contains no register decode; SPCR arrives as a decoded spcr_t.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (min 2)
DATA_W, 8, transfer width; SPI bytes only, fixed at 8

Ports:
clk  in  1  core clock; the only clock
rst  in  1  synchronous, active-high reset
spcr  in  8 (spcr_t)  live control: spe, dord, mstr, cpol, cpha used; spie/spr ignored
sck_i  in  1  async external SCK
mosi_i  in  1  async external MOSI
ss_n_i  in  1  async external SS, active low
miso_o  out  1  serial data out
miso_oe  out  1  MISO pad enable
tx_data  in  8  byte to load for next transfer
tx_wr  in  1  one-cycle SPDR write strobe
rx_data  out  8  last complete received byte
rx_done  out  1  one-cycle pulse: byte complete (sets SPIF)
wcol  out  1  one-cycle pulse: tx_wr while busy
busy  out  1  transfer in progress

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, shifter 0, bit_cnt 0, state IDLE, synchronizers loaded with idle values (sck=cpol, ss_n=1).
- enable = spe & ~mstr. If enable=0: forced IDLE, miso_oe=0, miso_o=0. tx_wr is still accepted into the shifter.
- Synchronizers: SYNC_STAGES flops per input, plus one history flop on sck/ss_n for edge detection. Input-to-detect latency is SYNC_STAGES+1 clk. SCK must be at most clk/4.
- Edge definitions:
  - lead = synced sck leaves cpol level; trail = returns to cpol.
  - cpha=0: sample on lead, shift on trail.
  - cpha=1: shift on lead, sample on trail.
- Bit order: dord=0 → MSB out first and MOSI enters at bit0 (shift left); dord=1 → LSB first (shift right).
- FSM (state_t in pkg):
  - IDLE: miso_oe=0. On synced ss_n falling & enable → SHIFT; bit_cnt=0; miso_oe=1; if cpha=0, drive first bit immediately from shifter.
  - SHIFT: each sample edge captures MOSI into a sample flop and increments bit_cnt. Each shift edge shifts the shifter and presents the next bit on miso_o; with cpha=1 the first lead edge presents bit 0 without shifting. On the 8th sample edge: rx_data ← assembled byte, and the shifter holds the same byte, so an unwritten next transfer echoes it (AVR behaviour). Then → DONE.
  - DONE (1 cycle): rx_done=1, bit_cnt=0. → SHIFT if ss_n still low and enable, else IDLE. Back-to-back bytes need no ss_n toggle.
- busy = (state==SHIFT) & (bit_cnt!=0 or a first edge has been seen).
- tx_wr:
  - if !busy: shifter ← tx_data next cycle; miso_o updates if cpha=0 and ss active.
  - if busy: wcol pulses next cycle; shifter is unchanged.
  - tx_wr in the same cycle as DONE is accepted (not busy).
- ss_n rising mid-byte (abort): → IDLE next detect cycle; bit_cnt=0; no rx_done; rx_data unchanged; shifter keeps partial content; miso_oe=0.
- Clearing spe or setting mstr mid-byte has the same effect as an abort.
- SPCR changes while SHIFT are undefined for that byte; the engine uses the live values.
- rx_done and wcol are never asserted together from the same tx_wr.

Decomposition:
- avr_spi_pkg gains state_t {IDLE, SHIFT, DONE} and an spi_mode_t enum built from {cpol,cpha}. Reuse spcr_t and dbus2spcr.
- Sub-module avr_spi_sync: parameterised SYNC_STAGES synchronizer with reset value input, instantiated for sck, mosi, ss_n.

Test Plan:
- Mode 0, dord=0, tx_wr 0x3C, master sends 0xA5 at clk/8 → miso bits 0,0,1,1,1,1,0,0; rx_data=0xA5; one rx_done; wcol never.
- Mode 3, dord=1, tx 0x81, master sends 0x96 → MISO LSB first 1,0,0,0,0,0,0,1; rx_data=0x96.
- ss_n held low, two bytes 0x11 then 0x22, no tx_wr after first → second byte transmits 0x11 (echo); two rx_done pulses; rx_data ends 0x22.
- tx_wr 0x55 after 3 SCK edges of a byte → wcol pulse 1 cycle; transmitted byte unchanged; rx_done still at bit 8.
- ss_n rises after 5 bits of 0xFF, then new byte 0x0F → no rx_done for the aborted byte; next rx_data=0x0F; miso_oe low between.
- spe=0 or mstr=1 with SCK/SS toggling → miso_oe=0, no rx_done/busy; rst mid-transfer → all outputs 0 next cycle.
